// File: rtl/ofm_writeback_scheduler.sv
// OFM writeback scheduler: ping-pong capture of 16 activated PE outputs, drained as
// four 32-bit words per entry. Optional `OFM_WB_BYTE_ADDR_EN` turns wr_addr_o into a byte address.
module ofm_writeback_scheduler #(
    parameter int NUM_PE = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [7:0]               OFM_W,
    input  logic [7:0]               OFM_C,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     finish_in,
    input  logic [NUM_PE*DATA_W-1:0] ofm_in,
    output logic                     stall_o,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [31:0]              wr_data_o,
    input  logic                     wr_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o,
    output logic                     cfg_err_o
);
    localparam int EW = NUM_PE * DATA_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t               state;
    logic [1:0][EW-1:0]   buffer;
    logic                 head, tail;
    logic [1:0]           count, k;
    logic [15:0]          pix, pix_last;
    logic [3:0]           grp, grp_last;
    logic [5:0]           c4;
    logic [ADDR_W-1:0]    base_q;

    logic                 accept, free, last, capture, cap_ok, cfg_ok;
    logic [21:0]          prod;
    logic [ADDR_W-1:0]    word_addr;

    assign cfg_ok  = (OFM_W != 8'd0) && (OFM_C != 8'd0) && (OFM_C[3:0] == 4'd0);
    assign wr_en_o = (state == ACTIVE) && (count != 2'd0);
    assign accept  = wr_en_o && wr_ready_i;
    assign free    = accept && (k == 2'd3);
    assign last    = free && (pix == pix_last) && (grp == grp_last);
    assign capture = (state == ACTIVE) && finish_in;
    // A full buffer still takes a capture when the head frees in the same cycle.
    assign cap_ok  = capture && ((count != 2'd2) || free);
    assign stall_o = (count == 2'd2);

    assign wr_data_o = buffer[head][{k, 5'b0} +: 32];
    assign prod      = {6'd0, pix} * {16'd0, c4};
    assign word_addr = base_q + {{(ADDR_W-22){1'b0}}, prod}
                     + {{(ADDR_W-6){1'b0}}, grp, 2'b00}
                     + {{(ADDR_W-2){1'b0}}, k};

`ifdef OFM_WB_BYTE_ADDR_EN
    assign wr_addr_o = word_addr << 2;
`else
    assign wr_addr_o = word_addr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            buffer     <= '0;
            head       <= 1'b0;
            tail       <= 1'b0;
            count      <= 2'd0;
            k          <= 2'd0;
            pix        <= 16'd0;
            pix_last   <= 16'd0;
            grp        <= 4'd0;
            grp_last   <= 4'd0;
            c4         <= 6'd0;
            base_q     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
            cfg_err_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            state      <= ACTIVE;
                            busy_o     <= 1'b1;
                            pix_last   <= {8'd0, OFM_W} * {8'd0, OFM_W} - 16'd1;
                            grp_last   <= OFM_C[7:4] - 4'd1;
                            c4         <= OFM_C[7:2];
                            base_q     <= base_addr;
                            head       <= 1'b0;
                            tail       <= 1'b0;
                            count      <= 2'd0;
                            k          <= 2'd0;
                            pix        <= 16'd0;
                            grp        <= 4'd0;
                            overflow_o <= 1'b0;
                            cfg_err_o  <= 1'b0;
                        end else begin
                            cfg_err_o <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (cap_ok) begin
                        buffer[tail] <= ofm_in;
                        tail         <= ~tail;
                    end else if (capture) begin
                        overflow_o <= 1'b1;
                    end
                    if (accept) k <= k + 2'd1;
                    if (free) begin
                        head <= ~head;
                        if (pix == pix_last) begin
                            pix <= 16'd0;
                            grp <= grp + 4'd1;
                        end else begin
                            pix <= pix + 16'd1;
                        end
                    end
                    count <= count + {1'b0, cap_ok} - {1'b0, free};
                    // Anything captured past the final pixel belongs to no job.
                    if (last) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        count  <= 2'd0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ofm_writeback_scheduler.sv
// Bench for ofm_writeback_scheduler: per-cycle scoreboard of expected writes built from
// the job geometry, a config table, and hand sequences for stall, free+capture and reset.
module tb_ofm_writeback_scheduler;
    logic         clk = 1'b0;
    logic         reset, start, finish_in, wr_ready_i;
    logic [7:0]   OFM_W, OFM_C;
    logic [31:0]  base_addr;
    logic [127:0] ofm_in;
    logic         stall_o, wr_en_o, busy_o, done_o, overflow_o, cfg_err_o;
    logic [31:0]  wr_addr_o, wr_data_o;

    ofm_writeback_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .OFM_W(OFM_W), .OFM_C(OFM_C),
        .base_addr(base_addr), .finish_in(finish_in), .ofm_in(ofm_in),
        .stall_o(stall_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
        .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i), .busy_o(busy_o),
        .done_o(done_o), .overflow_o(overflow_o), .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [7:0] w; logic [7:0] c; logic [31:0] base; bit ok; } cfg_vec_t;

    int tests = 0, fails = 0;

    // Reference model: a queue of every word still owed to the BRAM, in order.
    wr_t         q[$];
    bit          m_active, m_done, m_ovf, m_cerr;
    int          m_w2, m_c4, m_total, m_ncap, m_nfree;
    logic [31:0] m_base;
    int          n_acc, n_done;

    logic [7:0]   cfg_w, cfg_c;
    logic [31:0]  cfg_b;
    bit           fixed_pat;
    logic [127:0] lanes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int n, input int kk);
        int pix, grp;
        logic [31:0] a;
        pix = n % m_w2;
        grp = n / m_w2;
        a = m_base + 32'(pix * m_c4 + grp * 4 + kk);
`ifdef OFM_WB_BYTE_ADDR_EN
        a = a << 2;
`endif
        return a;
    endfunction

    task automatic model_clear();
        q.delete();
        m_active = 0; m_done = 0; m_ovf = 0; m_cerr = 0;
        m_ncap = 0; m_nfree = 0; m_base = 0;
    endtask

    task automatic cyc(input bit st, input bit fin, input bit rdy);
        logic [127:0] d;
        bit exp_en, accept, freeing, idle_now, nd;
        int outstanding;
        d = fixed_pat ? lanes : {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = st; OFM_W = cfg_w; OFM_C = cfg_c; base_addr = cfg_b;
        finish_in = fin; ofm_in = d; wr_ready_i = rdy;
        #1;
        outstanding = (q.size() + 3) / 4;
        exp_en = m_active && (q.size() > 0);
        chk("wr_en", 32'(wr_en_o), 32'(exp_en));
        if (exp_en) begin
            chk("wr_addr", wr_addr_o, q[0].addr);
            chk("wr_data", wr_data_o, q[0].data);
        end
        chk("stall", 32'(stall_o), 32'(outstanding == 2));
        chk("busy", 32'(busy_o), 32'(m_active));
        chk("done", 32'(done_o), 32'(m_done));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        chk("cfg_err", 32'(cfg_err_o), 32'(m_cerr));
        if (done_o) n_done++;
        accept   = exp_en && rdy;
        freeing  = accept && (q.size() % 4 == 1);
        idle_now = !m_active && !m_done;
        nd = 0;
        if (accept) n_acc++;
        if (m_active) begin
            if (fin) begin
                if (outstanding < 2 || freeing) begin
                    for (int kk = 0; kk < 4; kk++) begin
                        wr_t e;
                        e.addr = exp_addr(m_ncap, kk);
                        e.data = d[32*kk +: 32];
                        q.push_back(e);
                    end
                    m_ncap++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (accept) begin
                void'(q.pop_front());
                if (freeing) begin
                    m_nfree++;
                    if (m_nfree == m_total) begin
                        m_active = 0; nd = 1; q.delete();
                    end
                end
            end
        end else if (idle_now && st) begin
            if (cfg_w != 0 && cfg_c != 0 && cfg_c[3:0] == 0) begin
                q.delete();
                m_active = 1; m_ovf = 0; m_cerr = 0; m_ncap = 0; m_nfree = 0;
                m_base = cfg_b; m_w2 = int'(cfg_w) * int'(cfg_w); m_c4 = int'(cfg_c) / 4;
                m_total = m_w2 * (int'(cfg_c) / 16);
            end else begin
                m_cerr = 1;
            end
        end
        m_done = nd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; start = 0; finish_in = 0;
        #1;
        model_clear();
        chk("rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("rst_wr_addr", wr_addr_o, 32'd0);
        chk("rst_wr_data", wr_data_o, 32'd0);
        chk("rst_flags", {26'd0, stall_o, busy_o, done_o, overflow_o, cfg_err_o, 1'b0}, 32'd0);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic run_to_done(input int fin_pct, input int rdy_pct);
        int b = 0;
        while (!m_done && b < 3000) begin
            cyc(0, ($urandom % 100) < fin_pct, ($urandom % 100) < rdy_pct);
            b++;
        end
        tests++;
        if (!m_done) begin
            fails++;
            $display("FAIL job_timeout: got no completion expected done within 3000 cycles");
        end
        cyc(0, 0, 1);
    endtask

    cfg_vec_t tbl[6];
    logic [31:0] hold_a, hold_d, first_addr;

    initial begin
        tbl[0] = '{w: 8'd1, c: 8'd32, base: 32'h200,      ok: 1'b1};
        tbl[1] = '{w: 8'd2, c: 8'd24, base: 32'h0,        ok: 1'b0};
        tbl[2] = '{w: 8'd3, c: 8'd16, base: 32'hFFFFFFF0, ok: 1'b1};
        tbl[3] = '{w: 8'd0, c: 8'd16, base: 32'h0,        ok: 1'b0};
        tbl[4] = '{w: 8'd2, c: 8'd48, base: 32'h40,       ok: 1'b1};
        tbl[5] = '{w: 8'd1, c: 8'd0,  base: 32'h0,        ok: 1'b0};
        for (int i = 0; i < 16; i++) lanes[8*i +: 8] = 8'(i + 1);
`ifdef OFM_WB_BYTE_ADDR_EN
        first_addr = 32'h400;
`else
        first_addr = 32'h100;
`endif
        reset = 1; start = 0; finish_in = 0; wr_ready_i = 0;
        OFM_W = 0; OFM_C = 0; base_addr = 0; ofm_in = 0;
        cfg_w = 0; cfg_c = 0; cfg_b = 0; fixed_pat = 0; n_acc = 0; n_done = 0;
        model_clear();
        do_reset();
        cyc(0, 1, 1);

        // Basic drain with the fixed lane pattern.
        fixed_pat = 1; cfg_w = 2; cfg_c = 16; cfg_b = 32'h100;
        cyc(1, 0, 1);
        n_done = 0;
        for (int p = 0; p < 4; p++) begin
            cyc(0, 1, 1);
            if (p == 0) begin
                cyc(0, 0, 1);
                chk("basic_first_addr", wr_addr_o, first_addr);
                chk("basic_word0", wr_data_o, 32'h04030201);
                for (int j = 0; j < 6; j++) cyc(0, 0, 1);
            end else begin
                for (int j = 0; j < 7; j++) cyc(0, 0, 1);
            end
        end
        for (int j = 0; j < 3; j++) cyc(0, 0, 1);
        chk("basic_done_pulses", 32'(n_done), 32'd1);
        fixed_pat = 0;

        // Config table: each row is started, checked, and (if valid) run to completion.
        foreach (tbl[i]) begin
            cfg_w = tbl[i].w; cfg_c = tbl[i].c; cfg_b = tbl[i].base;
            cyc(1, 0, 1);
            cyc(0, 0, 1);
            chk("tbl_busy", 32'(busy_o), 32'(tbl[i].ok));
            chk("tbl_cfg_err", 32'(cfg_err_o), 32'(!tbl[i].ok));
            if (tbl[i].ok) run_to_done(30, 75);
        end

        // Back-pressure: three back-to-back captures while the BRAM refuses writes.
        cfg_w = 2; cfg_c = 16; cfg_b = 32'h0;
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("bp_stall", 32'(stall_o), 32'd1);
        cyc(0, 0, 0);
        chk("bp_overflow", 32'(overflow_o), 32'd1);
        hold_a = wr_addr_o; hold_d = wr_data_o;
        for (int j = 0; j < 6; j++) begin
            cyc(0, 0, 0);
            chk("bp_hold_addr", wr_addr_o, hold_a);
            chk("bp_hold_data", wr_data_o, hold_d);
        end
        run_to_done(25, 100);

        // Simultaneous free + capture with both entries full.
        cyc(1, 0, 1);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        cyc(0, 0, 1);
        chk("sim_no_overflow", 32'(overflow_o), 32'd0);
        chk("sim_still_full", 32'(stall_o), 32'd1);
        run_to_done(20, 100);

        // Reset after five accepted words, then a fresh job from base.
        cfg_b = 32'h100;
        cyc(1, 0, 1);
        n_acc = 0;
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        while (n_acc < 5) cyc(0, 0, 1);
        do_reset();
        for (int j = 0; j < 4; j++) cyc(0, 1, 1);
        chk("rst_no_write", 32'(wr_en_o), 32'd0);
        cyc(1, 0, 1);
        cyc(0, 1, 1);
        cyc(0, 0, 0);
        chk("rst_restart_addr", wr_addr_o, first_addr);
        run_to_done(30, 80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
